// File: rtl/secure_reg_arb.sv
// ============================================================================
// Module   : secure_reg_arb
// Brief    : Round-robin arbiter sequencing NREQ requesters onto a NREG bank
//            under a lockable read/write access policy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module secure_reg_arb #(
    parameter int NREQ = 3,
    parameter int NREG = 3,
    parameter int DW   = 8,
    parameter int AW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [2:0]         cfg,
    output logic [2:0]         cfg_q,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic               rsp_err,
    output logic [DW-1:0]      rsp_rdata,
    output logic [NREG-1:0]    reg_re,
    output logic [NREG-1:0]    reg_we,
    output logic [DW-1:0]      reg_wd,
    input  logic [NREG*DW-1:0] reg_rd
);

    localparam int c_IW = $clog2(NREQ);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]      r_state;
    logic [c_IW-1:0] r_last;
    logic [c_IW-1:0] r_win;
    logic            r_wr;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_err;
    logic [DW-1:0]   r_rdata;
    logic [2:0]      r_cfg;

    logic            w_any;
    logic [c_IW-1:0] w_win;
    int              w_best;
    logic            w_sel_wr;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_addr_ok;
    logic [DW-1:0]   w_rd;
    logic            w_err;

    assign cfg_q = r_cfg;
    assign w_any = |req_valid;

    // Winner is the valid requester with the smallest rotational distance past r_last.
    always_comb begin
        w_win  = '0;
        w_best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (((i + NREQ - 1 - int'(r_last)) % NREQ) < w_best)) begin
                w_best = (i + NREQ - 1 - int'(r_last)) % NREQ;
                w_win  = c_IW'(i);
            end
        end
    end

    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_IW'(i)) begin
                w_sel_wr    = req_wr[i];
                w_sel_addr  = req_addr[i*AW +: AW];
                w_sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_addr_ok = 1'b0;
        w_rd      = '0;
        for (int j = 0; j < NREG; j++) begin
            if (r_addr == AW'(j)) begin
                w_addr_ok = 1'b1;
                w_rd      = reg_rd[j*DW +: DW];
            end
        end
        w_err = !w_addr_ok | (r_wr & !r_cfg[1]) | (!r_wr & !r_cfg[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_last  <= c_IW'(NREQ - 1);
            r_win   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_cfg   <= 3'b000;
        end else begin
            if (cfg_we && !r_cfg[2]) begin
                r_cfg <= cfg;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_win   <= w_win;
                        r_last  <= w_win;
                        r_wr    <= w_sel_wr;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    r_err   <= w_err;
                    r_rdata <= (!w_err && !r_wr) ? w_rd : '0;
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from state and forced low while rst is high so an aborted access never strobes.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        reg_re    = '0;
        reg_we    = '0;
        reg_wd    = '0;
        if (!rst) begin
            case (r_state)
                c_IDLE: begin
                    for (int i = 0; i < NREQ; i++) begin
                        req_ready[i] = w_any && (w_win == c_IW'(i));
                    end
                end
                c_ACCESS: begin
                    reg_wd = r_wdata;
                    for (int j = 0; j < NREG; j++) begin
                        if (!w_err && (r_addr == AW'(j))) begin
                            reg_we[j] = r_wr;
                            reg_re[j] = !r_wr;
                        end
                    end
                end
                c_RESP: begin
                    for (int i = 0; i < NREQ; i++) begin
                        rsp_valid[i] = (r_win == c_IW'(i));
                    end
                    rsp_err   = r_err;
                    rsp_rdata = r_rdata;
                end
                default: begin
                    req_ready = '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
